// File: rtl/piso_seq_pkg.sv
// Shared types and helpers for the PISO sequencer.
package piso_seq_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    // Even parity over the low n bits of d (XOR of those bits)
    function automatic logic even_parity(input logic [31:0] d, input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, right-shifting register; ones fill in behind the data so
// the serial output idles high.
module piso_shift_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    output logic         ser_out
);

    logic [W-1:0] sr_d;
    logic [W-1:0] sr_q;

    // Next register value: load wins over shift
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = {1'b1, sr_q[W-1:1]};
        end
    end

    // Register state; reset to all ones so the line idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_out = sr_q[0];

endmodule

// File: rtl/piso_seq_ctrl.sv
// PISO sequencer: accepts words on a valid/ready handshake and sends them
// LSB-first, DIV clocks per bit. Optional macro PISO_SEQ_PARITY_EN appends
// an even parity bit after the data bits.
module piso_seq_ctrl
    import piso_seq_pkg::*;
#(
    parameter int M   = 5,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [M-1:0] in_data,
    output logic         in_ready,
    output logic         ser_out,
    output logic         busy,
    output logic         done
);

`ifdef PISO_SEQ_PARITY_EN
    localparam int FRAME = M + 1;
`else
    localparam int FRAME = M;
`endif

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(FRAME + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

    piso_state_t      state_d, state_q;
    logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d, bit_cnt_q;
    logic             done_d, done_q;
    logic             load;
    logic             shift;
    logic [FRAME-1:0] load_data;

`ifdef PISO_SEQ_PARITY_EN
    assign load_data = {even_parity(32'(in_data), M), in_data};
`else
    assign load_data = in_data;
`endif

    // Next-state, counter and strobe logic for the frame sequencer
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_d   = SHIFT;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    shift     = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == IDLE) & ~reset;
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;

    piso_shift_reg #(
        .W(FRAME)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .shift    (shift),
        .ser_out  (ser_out)
    );

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Directed bench for piso_seq_ctrl: one instance with DIV=4, one with DIV=1.
module tb_piso_seq_ctrl;

    localparam int M = 5;
`ifdef PISO_SEQ_PARITY_EN
    localparam int FRAME = M + 1;
`else
    localparam int FRAME = M;
`endif

    logic         clk;
    logic         reset;
    logic         a_valid, b_valid;
    logic [M-1:0] a_data, b_data;
    logic         a_ready, b_ready;
    logic         a_ser, b_ser;
    logic         a_busy, b_busy;
    logic         a_done, b_done;

    int vecs = 0;
    int errs = 0;

    piso_seq_ctrl #(.M(M), .DIV(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .ser_out(a_ser), .busy(a_busy), .done(a_done)
    );

    piso_seq_ctrl #(.M(M), .DIV(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .ser_out(b_ser), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame bit k: data LSB-first, then parity when enabled
    function automatic logic exp_bit(input logic [M-1:0] w, input int k);
        if (k < M) return w[k];
        return ^w;
    endfunction

    // Check one DIV=4 frame (accept edge already passed); mode 0 drops
    // in_valid, mode 1 holds it with word nxt, mode 2 randomizes inputs.
    // Returns at the done-cycle negedge after checking it.
    task automatic shift_a(input logic [M-1:0] w, input int mode, input logic [M-1:0] nxt);
        for (int c = 1; c <= FRAME * 4; c++) begin
            @(negedge clk);
            chk($sformatf("a_ser c%0d", c), 32'(a_ser), 32'(exp_bit(w, (c - 1) / 4)));
            chk($sformatf("a_busy c%0d", c), 32'(a_busy), 32'd1);
            chk($sformatf("a_ready c%0d", c), 32'(a_ready), 32'd0);
            chk($sformatf("a_done c%0d", c), 32'(a_done), 32'd0);
            if (mode == 0) begin
                a_valid = 1'b0;
            end else if (mode == 1) begin
                a_valid = 1'b1;
                a_data  = nxt;
            end else begin
                a_valid = 1'($urandom);
                a_data  = M'($urandom);
            end
        end
        @(negedge clk);
        chk("a_done pulse", 32'(a_done), 32'd1);
        chk("a_ready done", 32'(a_ready), 32'd1);
        chk("a_busy done", 32'(a_busy), 32'd0);
        chk("a_ser done", 32'(a_ser), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        b_valid = 1'b0;
        b_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("ready in reset", 32'(a_ready), 32'd0);
        chk("ser in reset", 32'(a_ser), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst ready", 32'(a_ready), 32'd1);
        chk("rst ser", 32'(a_ser), 32'd1);
        chk("rst busy", 32'(a_busy), 32'd0);
        chk("rst done", 32'(a_done), 32'd0);
        chk("rst b_ser", 32'(b_ser), 32'd1);

        // Single word 10110
        a_valid = 1'b1;
        a_data  = 5'b10110;
        shift_a(5'b10110, 0, '0);
        a_valid = 1'b0;
        @(negedge clk);
        chk("post done low", 32'(a_done), 32'd0);
        chk("post ser idle", 32'(a_ser), 32'd1);
        chk("post busy", 32'(a_busy), 32'd0);

        // Back-to-back with in_valid held high
        a_valid = 1'b1;
        a_data  = 5'b00011;
        shift_a(5'b00011, 1, 5'b11100);
        shift_a(5'b11100, 0, '0);
        a_valid = 1'b0;
        @(negedge clk);
        chk("b2b idle done", 32'(a_done), 32'd0);

        // Inputs toggled randomly during the frame
        a_valid = 1'b1;
        a_data  = 5'b01101;
        shift_a(5'b01101, 2, '0);
        a_valid = 1'b0;
        @(negedge clk);
        chk("rand idle busy", 32'(a_busy), 32'd0);

        // Reset in cycle 10 aborts the frame
        a_valid = 1'b1;
        a_data  = 5'b11001;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            a_valid = 1'b0;
            chk($sformatf("abort ser c%0d", c), 32'(a_ser), 32'(exp_bit(5'b11001, (c - 1) / 4)));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort ser", 32'(a_ser), 32'd1);
        chk("abort busy", 32'(a_busy), 32'd0);
        chk("abort ready", 32'(a_ready), 32'd1);
        chk("abort done", 32'(a_done), 32'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk($sformatf("no done c%0d", c), 32'(a_done), 32'd0);
        end

        // DIV=1 instance, word 00001
        b_valid = 1'b1;
        b_data  = 5'b00001;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            b_valid = 1'b0;
            chk($sformatf("b_ser c%0d", c), 32'(b_ser), 32'(exp_bit(5'b00001, c - 1)));
            chk($sformatf("b_busy c%0d", c), 32'(b_busy), 32'd1);
            chk($sformatf("b_done c%0d", c), 32'(b_done), 32'd0);
        end
        @(negedge clk);
        chk("b_done pulse", 32'(b_done), 32'd1);
        chk("b_ready done", 32'(b_ready), 32'd1);
        chk("b_ser done", 32'(b_ser), 32'd1);
        @(negedge clk);
        chk("b_done low", 32'(b_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
